// File: rtl/serial_add_gp_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding, the legal WIDTH range and counter sizing.
package serial_add_gp_ctrl_pkg;

   // 2-bit state encoding: IDLE=0, RUN=1, DONE=2.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;

   // True when the operand width is within the supported range.
   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

   // Bit counter width: clog2(WIDTH), but never narrower than one bit.
   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_add_gp_ctrl_if.sv
// Request/result bus of the bit-serial add/subtract controller.
//
// Handshake: the requester raises start with sub/cin/a/b stable; the
// request is taken on the rising edge where start=1 and ready=1 (ready is
// high only while idle). A start seen while not ready is dropped, never
// queued. busy is high while bits are being processed. done is a single
// cycle pulse during which sum/cout/ovf/grp_g/grp_p are final; these hold
// their values until the next accepted request.
interface serial_add_gp_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             grp_g;
   logic             grp_p;

   modport master (
      output start, sub, cin, a, b,
      input  ready, busy, done, sum, cout, ovf, grp_g, grp_p
   );

   modport slave (
      input  start, sub, cin, a, b,
      output ready, busy, done, sum, cout, ovf, grp_g, grp_p
   );
endinterface

// File: rtl/serial_add_gp_ctrl_full_adder_gp.sv
// One-bit full adder slice that also reports its bit generate (A&B)
// and propagate (A^B) terms. Port order is S, C, G, P, A, B, C0.
module full_adder_gp (
   output logic S,
   output logic C,
   output logic G,
   output logic P,
   input  logic A,
   input  logic B,
   input  logic C0
);
   // Purely combinational sum, carry and generate/propagate terms.
   always_comb begin
      G = A & B;
      P = A ^ B;
      S = P ^ C0;
      C = G | (P & C0);
   end
endmodule

// File: rtl/serial_add_gp_ctrl.sv
// Bit-serial add/subtract controller. A single full_adder_gp slice is
// reused once per clock, LSB first, to form the sum, carry-out, signed
// overflow and the group generate/propagate of the whole word.
module serial_add_gp_ctrl
   import serial_add_gp_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_add_gp_ctrl_if.slave  bus,
   output state_t               dbg_state_o
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_add_gp_ctrl: WIDTH must be in 1..32");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             grp_g_q, grp_g_d;
   logic             grp_p_q, grp_p_d;

   logic fa_s, fa_c, fa_g, fa_p;

   full_adder_gp u_fa (fa_s, fa_c, fa_g, fa_p, a_sh_q[0], b_sh_q[0], carry_q);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and next datapath values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      grp_g_d = grp_g_q;
      grp_p_d = grp_p_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               // Subtraction is a + ~b + 1.
               a_sh_d  = bus.a;
               b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.sub ? 1'b1 : bus.cin;
               grp_g_d = 1'b0;
               grp_p_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Sum bits enter at the top so bit i lands at position i
            // after WIDTH shifts.
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_c;
            grp_g_d = fa_g | (fa_p & grp_g_q);
            grp_p_d = grp_p_q & fa_p;
            if (cnt_q == LAST_BIT) begin
               // carry_q is the carry into the MSB at this point.
               ovf_d   = carry_q ^ fa_c;
               cout_d  = fa_c;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath registers; reset clears every result and the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         grp_g_q <= 1'b0;
         grp_p_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         grp_g_q <= grp_g_d;
         grp_p_q <= grp_p_d;
      end
   end

   // Status and result outputs decoded straight from registers.
   always_comb begin
      bus.ready   = (state_q == ST_IDLE);
      bus.busy    = (state_q == ST_RUN);
      bus.done    = (state_q == ST_DONE);
      bus.sum     = sum_q;
      bus.cout    = cout_q;
      bus.ovf     = ovf_q;
      bus.grp_g   = grp_g_q;
      bus.grp_p   = grp_p_q;
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_serial_add_gp_ctrl.sv
// Directed bench for serial_add_gp_ctrl at WIDTH=8.
module tb_serial_add_gp_ctrl;
   import serial_add_gp_ctrl_pkg::*;

   localparam int W = 8;

   logic   clk;
   logic   rst;
   state_t dbg_state;
   int     checks;
   int     failures;

   serial_add_gp_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_gp_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock: 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Starts an op from IDLE (called #1 after an edge). lat returns the
   // number of edges after the accept edge until done is seen (40 = none).
   // Inputs are scrambled after accept; the result must not depend on them.
   task automatic run_op(input logic s, input logic c, input logic [W-1:0] av,
                         input logic [W-1:0] bv, output int lat);
      bus.start = 1'b1;
      bus.sub   = s;
      bus.cin   = c;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.sub   = ~s;
      bus.cin   = ~c;
      bus.a     = ~av;
      bus.b     = ~bv;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h want=00", bus.sum); end
      checks++; if ({bus.cout, bus.ovf, bus.grp_g, bus.grp_p} !== 4'b0000) begin failures++;
         $display("FAIL reset_flags got=%b want=0000", {bus.cout, bus.ovf, bus.grp_g, bus.grp_p}); end
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
   endtask

   task automatic test_add_carry();
      int lat;
      run_op(1'b0, 1'b0, 8'hFF, 8'h01, lat);
      checks++; if (lat !== 8) begin failures++; $display("FAIL ff01_latency got=%0d want=8", lat); end
      checks++; if (bus.sum !== 8'h00) begin failures++; $display("FAIL ff01_sum got=%h want=00", bus.sum); end
      checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL ff01_cout got=%b want=1", bus.cout); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ff01_ovf got=%b want=0", bus.ovf); end
      checks++; if (bus.grp_g !== 1'b1) begin failures++; $display("FAIL ff01_grp_g got=%b want=1", bus.grp_g); end
      checks++; if (bus.grp_p !== 1'b0) begin failures++; $display("FAIL ff01_grp_p got=%b want=0", bus.grp_p); end
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL ff01_ready_in_done got=%b want=0", bus.ready); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin failures++;
         $display("FAIL ff01_back_idle got done=%b ready=%b want done=0 ready=1", bus.done, bus.ready); end
      checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin failures++;
         $display("FAIL ff01_hold got sum=%h cout=%b want 00/1", bus.sum, bus.cout); end
   endtask

   task automatic test_add_ovf();
      int lat;
      run_op(1'b0, 1'b0, 8'h7F, 8'h01, lat);
      checks++; if (lat !== 8) begin failures++; $display("FAIL 7f01_latency got=%0d want=8", lat); end
      checks++; if (bus.sum !== 8'h80) begin failures++; $display("FAIL 7f01_sum got=%h want=80", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL 7f01_cout got=%b want=0", bus.cout); end
      checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL 7f01_ovf got=%b want=1", bus.ovf); end
      @(posedge clk); #1;
   endtask

   task automatic test_add_prop();
      int lat;
      run_op(1'b0, 1'b0, 8'h55, 8'hAA, lat);
      checks++; if (bus.sum !== 8'hFF) begin failures++; $display("FAIL 55aa_c0_sum got=%h want=ff", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL 55aa_c0_cout got=%b want=0", bus.cout); end
      checks++; if (bus.grp_p !== 1'b1) begin failures++; $display("FAIL 55aa_c0_grp_p got=%b want=1", bus.grp_p); end
      checks++; if (bus.grp_g !== 1'b0) begin failures++; $display("FAIL 55aa_c0_grp_g got=%b want=0", bus.grp_g); end
      @(posedge clk); #1;
      run_op(1'b0, 1'b1, 8'h55, 8'hAA, lat);
      checks++; if (bus.sum !== 8'h00) begin failures++; $display("FAIL 55aa_c1_sum got=%h want=00", bus.sum); end
      checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL 55aa_c1_cout got=%b want=1", bus.cout); end
      checks++; if (bus.grp_p !== 1'b1) begin failures++; $display("FAIL 55aa_c1_grp_p got=%b want=1", bus.grp_p); end
      @(posedge clk); #1;
   endtask

   task automatic test_sub();
      int lat;
      run_op(1'b1, 1'b1, 8'h05, 8'h07, lat);
      checks++; if (bus.sum !== 8'hFE) begin failures++; $display("FAIL sub0507_sum got=%h want=fe", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL sub0507_cout got=%b want=0", bus.cout); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL sub0507_ovf got=%b want=0", bus.ovf); end
      @(posedge clk); #1;
      run_op(1'b1, 1'b0, 8'h80, 8'h01, lat);
      checks++; if (bus.sum !== 8'h7F) begin failures++; $display("FAIL sub8001_sum got=%h want=7f", bus.sum); end
      checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL sub8001_cout got=%b want=1", bus.cout); end
      checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sub8001_ovf got=%b want=1", bus.ovf); end
      @(posedge clk); #1;
   endtask

   // start held high: one result every 10 edges (accept edge is i=0).
   task automatic test_back_to_back();
      int n_done;
      int last_i;
      n_done = 0;
      last_i = -1;
      bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'h10; bus.b = 8'h20;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            checks++; if (i !== n_done * 10 + 8) begin failures++;
               $display("FAIL b2b_done_edge got=%0d want=%0d", i, n_done * 10 + 8); end
            checks++; if (bus.sum !== 8'h30) begin failures++; $display("FAIL b2b_sum got=%h want=30", bus.sum); end
            n_done++;
            last_i = i;
         end
      end
      bus.start = 1'b0;
      checks++; if (n_done !== 4) begin failures++; $display("FAIL b2b_count got=%0d want=4 last=%0d", n_done, last_i); end
      checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_end got=%b want=1", bus.ready); end
   endtask

   // start and new operands presented during RUN/DONE must be ignored.
   task automatic test_ignore_start();
      int lat;
      bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'h12; bus.b = 8'h34;
      @(posedge clk); #1;
      bus.sub = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      checks++; if (dbg_state !== ST_RUN || bus.busy !== 1'b1) begin failures++;
         $display("FAIL ign_run got state=%0d busy=%b want 1/1", dbg_state, bus.busy); end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat !== 8) begin failures++; $display("FAIL ign_latency got=%0d want=8", lat); end
      checks++; if (bus.sum !== 8'h46) begin failures++; $display("FAIL ign_sum got=%h want=46", bus.sum); end
      bus.start = 1'b0;
      @(posedge clk); #1;
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL ign_no_queue got=%0d want=0", dbg_state); end
   endtask

   task automatic test_rst_mid_run();
      int lat;
      int seen;
      bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL rst_pre_state got=%0d want=1", dbg_state); end
      rst = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start = 1'b0;
      checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
         $display("FAIL rst_mid_status got r/b/d=%b%b%b want 100", bus.ready, bus.busy, bus.done); end
      checks++; if (bus.sum !== 8'h00) begin failures++; $display("FAIL rst_mid_sum got=%h want=00", bus.sum); end
      checks++; if ({bus.cout, bus.ovf, bus.grp_g, bus.grp_p} !== 4'b0000) begin failures++;
         $display("FAIL rst_mid_flags got=%b want=0000", {bus.cout, bus.ovf, bus.grp_g, bus.grp_p}); end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d want=0", seen); end
      run_op(1'b0, 1'b0, 8'h03, 8'h04, lat);
      checks++; if (bus.sum !== 8'h07) begin failures++; $display("FAIL rst_after_sum got=%h want=07", bus.sum); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL rst_after_latency got=%0d want=8", lat); end
      @(posedge clk); #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add_carry();
      test_add_ovf();
      test_add_prop();
      test_sub();
      test_back_to_back();
      test_ignore_start();
      test_rst_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
